// File: rtl/uart_pkg.sv
// uart_pkg: types and line levels shared by the UART transmit serializer and the
// future receiver.
// Contents: uart_state_e (frame-sequencer states), IDLE_LEVEL, START_LEVEL and
// STOP_LEVEL.
// Build option: when UART_TX_PARITY_EN is defined, a PARITY state is added to the
// enum. Leave the macro undefined for a frame with no parity bit.
package uart_pkg;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: host-side start/busy/done handshake for the UART
// transmitter.
// Signals:
//   tx_start  request to send tx_data
//   tx_data   word to send; sampled only in the cycle the request is accepted
//   tx_busy   frame in progress
//   tx_done   one-cycle pulse at frame end
// Modports: master = host logic, slave = serializer.
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (output tx_start, output tx_data, input tx_busy, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx_busy, output tx_done);
endinterface

// File: rtl/uart_tick_edge.sv
// uart_tick_edge: rising-edge detector for the baud divider's square wave.
// Ports:
//   clk_in  system clock
//   reset   synchronous, active-high; clears the delayed copy of sig
//   sig     baud_clk from the divider
//   tick    high for the one clk_in cycle in which sig has just risen
module uart_tick_edge (
  input  logic clk_in,
  input  logic reset,
  input  logic sig,
  output logic tick
);
  logic sig_q;

  always_ff @(posedge clk_in) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig;
  end

  assign tick = sig & ~sig_q;
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: shifts a parallel word out LSB-first as an asynchronous
// UART frame (start, data, optional even parity, stop). All line transitions
// happen on a tick, which marks a rising edge of baud_clk.
// Ports:
//   clk_in      system clock (the baud divider runs on the same clock)
//   reset       synchronous, active-high
//   baud_clk    divider square wave; one bit period is one baud_clk period
//   serial_out  UART line; high when idle
//   host        start/busy/done handshake (slave modport)
// Parameters: DATA_BITS (5..9), STOP_BITS (1 or 2).
// Build option: UART_TX_PARITY_EN adds an even-parity bit after the last data bit.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | line high; accepts tx_start and latches tx_data
// S_LOAD   | word latched; waiting for the tick that starts the start bit
// S_START  | start bit on the line
// S_DATA   | data bits on the line, LSB first
// S_PARITY | parity bit on the line (only with UART_TX_PARITY_EN)
// S_STOP   | stop bit(s) on the line; tx_done pulses at the end
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   baud_clk,
  output logic                   serial_out,
  uart_tx_serializer_if.slave    host
);
  localparam int                CNT_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e           state;
  logic [DATA_BITS-1:0]  shift;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  stop_cnt;
  logic                  busy_q;
  logic                  done_q;
  logic                  tick;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q;
`endif

  uart_tick_edge u_tick (
    .clk_in (clk_in),
    .reset  (reset),
    .sig    (baud_clk),
    .tick   (tick)
  );

  // A tick that arrives in the cycle a request is accepted is not used; the
  // start bit begins on the next tick.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state      <= S_IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      serial_out <= IDLE_LEVEL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          serial_out <= IDLE_LEVEL;
          busy_q     <= 1'b0;
          if (host.tx_start) begin
            shift    <= host.tx_data;
            bit_cnt  <= '0;
            busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^host.tx_data;
`endif
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (tick) begin
            serial_out <= START_LEVEL;
            state      <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            serial_out <= shift[0];
            state      <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            // bit_cnt only counts up from zero, so "not last" equals "below last".
            if (bit_cnt != BIT_LAST) begin
              shift      <= shift >> 1;
              bit_cnt    <= bit_cnt + 1'b1;
              serial_out <= shift[1];
            end else begin
`ifdef UART_TX_PARITY_EN
              serial_out <= parity_q;
              state      <= S_PARITY;
`else
              serial_out <= STOP_LEVEL;
              stop_cnt   <= 1'b0;
              state      <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (tick) begin
            serial_out <= STOP_LEVEL;
            stop_cnt   <= 1'b0;
            state      <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (tick) begin
            if (stop_cnt != STOP_LAST) begin
              stop_cnt <= 1'b1;
            end else begin
              serial_out <= IDLE_LEVEL;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state      <= S_IDLE;
            end
          end
        end
        default: begin
          serial_out <= IDLE_LEVEL;
          busy_q     <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  assign host.tx_busy = busy_q;
  assign host.tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: checks two serializers driven by one baud clock whose
// period is 8 system-clock cycles.
//   dut_a  DATA_BITS=8, STOP_BITS=1
//   dut_b  DATA_BITS=7, STOP_BITS=2
// Frame contents are predicted into a queue when each request is issued. Each
// bit is popped from the queue and compared against the line at the middle of
// its bit period. UART_TX_PARITY_EN is honoured, so the same bench covers both
// builds.
module tb_uart_tx_serializer;
  logic clk_in = 1'b0;
  logic reset;
  logic baud_clk;
  int   bphase;
  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  logic so_a, so_b;

  uart_tx_serializer_if #(.DATA_BITS(8)) if_a ();
  uart_tx_serializer_if #(.DATA_BITS(7)) if_b ();

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1)) dut_a (
    .clk_in     (clk_in),
    .reset      (reset),
    .baud_clk   (baud_clk),
    .serial_out (so_a),
    .host       (if_a)
  );

  uart_tx_serializer #(.DATA_BITS(7), .STOP_BITS(2)) dut_b (
    .clk_in     (clk_in),
    .reset      (reset),
    .baud_clk   (baud_clk),
    .serial_out (so_b),
    .host       (if_b)
  );

  always #5 clk_in = ~clk_in;

  // baud_clk is high in phases 0..3 and low in phases 4..7. It rises at the
  // negedge where the phase wraps from 7 to 0.
  initial begin
    bphase   = 0;
    baud_clk = 1'b0;
    forever begin
      @(negedge clk_in);
      bphase   = (bphase + 1) % 8;
      baud_clk = (bphase < 4);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic line_of(input int sel);
    return (sel == 0) ? so_a : so_b;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? if_a.tx_busy : if_b.tx_busy;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? if_a.tx_done : if_b.tx_done;
  endfunction

  // Queues the expected frame (start, data LSB-first, parity, stops) and
  // returns the frame length in bits.
  function automatic int push_frame(input int sel, input logic [8:0] data);
    int nb;
    int sb;
    int len;
    nb  = (sel == 0) ? 8 : 7;
    sb  = (sel == 0) ? 1 : 2;
    len = 0;
    exp_q.push_back(1'b0);
    len++;
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(data[i]);
      len++;
    end
`ifdef UART_TX_PARITY_EN
    begin
      logic p;
      p = 1'b0;
      for (int i = 0; i < nb; i++) p ^= data[i];
      exp_q.push_back(p);
      len++;
    end
`endif
    for (int i = 0; i < sb; i++) begin
      exp_q.push_back(1'b1);
      len++;
    end
    return len;
  endfunction

  // Raises tx_start on the next negedge and returns 1 time unit after the
  // posedge that accepts the request. tx_start is left asserted.
  task automatic send_req(input int sel, input logic [8:0] data);
    @(negedge clk_in);
    if (sel == 0) begin
      if_a.tx_start = 1'b1;
      if_a.tx_data  = data[7:0];
    end else begin
      if_b.tx_start = 1'b1;
      if_b.tx_data  = data[6:0];
    end
    @(posedge clk_in);
    #1;
  endtask

  // Call this 1 time unit after the accepting edge. It waits for the start bit,
  // compares each bit at mid-period against the queue, and checks that tx_done
  // arrives exactly len baud periods after the start bit falls. lat returns the
  // number of cycles from acceptance to the falling edge of the start bit.
  task automatic check_frame(input int sel, input int len, input string name, output int lat);
    bit   seen;
    int   c;
    int   popped;
    logic e;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_in);
      #1;
      if (line_of(sel) === 1'b0) begin
        lat  = i;
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s start: line=%b after 40 cycles, required 0", name, line_of(sel));
      repeat (len) if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    seen   = 1'b0;
    c      = 0;
    popped = 0;
    for (int i = 1; i <= 8 * len + 8; i++) begin
      @(posedge clk_in);
      #1;
      if (done_of(sel) === 1'b1) begin
        c    = i;
        seen = 1'b1;
        break;
      end
      if ((i % 8) == 4 && (i / 8) < len) begin
        e = exp_q.pop_front();
        popped++;
        checks++;
        if (line_of(sel) !== e || busy_of(sel) !== 1'b1) begin
          errors++;
          $display("FAIL %s bit%0d: line=%b busy=%b, required line=%b busy=1", name, i / 8, line_of(sel), busy_of(sel), e);
        end
      end
    end
    while (popped < len && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      popped++;
    end
    checks++;
    if (!seen || c != 8 * len) begin
      errors++;
      $display("FAIL %s done_time: seen=%0d cycles=%0d, required cycles=%0d", name, seen, c, 8 * len);
    end
    checks++;
    if (seen && busy_of(sel) !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: busy=%b, required 0", name, busy_of(sel));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in);
      #1;
      checks++;
      if (so_a !== 1'b1 || if_a.tx_busy !== 1'b0 || if_a.tx_done !== 1'b0 ||
          so_b !== 1'b1 || if_b.tx_busy !== 1'b0 || if_b.tx_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold%0d: a=%b%b%b b=%b%b%b (line,busy,done), required 100", i,
                 so_a, if_a.tx_busy, if_a.tx_done, so_b, if_b.tx_busy, if_b.tx_done);
      end
    end
    @(negedge clk_in);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in);
      #1;
      checks++;
      if (so_a !== 1'b1 || if_a.tx_busy !== 1'b0 || if_a.tx_done !== 1'b0 ||
          so_b !== 1'b1 || if_b.tx_busy !== 1'b0 || if_b.tx_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_after%0d: a=%b%b%b b=%b%b%b (line,busy,done), required 100", i,
                 so_a, if_a.tx_busy, if_a.tx_done, so_b, if_b.tx_busy, if_b.tx_done);
      end
    end
  endtask

  task automatic run_word(input int sel, input logic [8:0] data, input string name);
    int len;
    int lat;
    len = push_frame(sel, data);
    send_req(sel, data);
    checks++;
    if (busy_of(sel) !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_accept: busy=%b, required 1", name, busy_of(sel));
    end
    if (sel == 0) if_a.tx_start = 1'b0;
    else          if_b.tx_start = 1'b0;
    check_frame(sel, len, name, lat);
    checks++;
    if (lat < 1 || lat > 8) begin
      errors++;
      $display("FAIL %s start_latency: cycles=%0d, required 1..8", name, lat);
    end
    @(posedge clk_in);
    #1;
    checks++;
    if (done_of(sel) !== 1'b0 || busy_of(sel) !== 1'b0 || line_of(sel) !== 1'b1) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b line=%b, required 0 0 1", name, done_of(sel), busy_of(sel), line_of(sel));
    end
  endtask

  task automatic test_basic();
    run_word(0, 9'h055, "basic_55");
  endtask

  task automatic test_parity();
    run_word(0, 9'h055, "parity_55");
    run_word(0, 9'h007, "parity_07");
  endtask

  task automatic test_two_stop();
    run_word(1, 9'h041, "twostop_41");
  endtask

  task automatic test_ignore_midframe();
    int len;
    int lat;
    int bad;
    len = push_frame(0, 9'h03C);
    send_req(0, 9'h03C);
    if_a.tx_start = 1'b0;
    fork
      check_frame(0, len, "ignore_3C", lat);
      begin
        repeat (30) @(negedge clk_in);
        if_a.tx_start = 1'b1;
        if_a.tx_data  = 8'hFF;
        @(negedge clk_in);
        if_a.tx_start = 1'b0;
        if_a.tx_data  = 8'h00;
      end
    join
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk_in);
      #1;
      if (if_a.tx_busy !== 1'b0 || so_a !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ignore_no_requeue: busy/low cycles=%0d, required 0", bad);
    end
  endtask

  task automatic test_start_on_tick();
    int len;
    int lat;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk_in);
      #1;
      if (bphase == 7) begin
        found = 1'b1;
        break;
      end
    end
    len = push_frame(0, 9'h096);
    // The next negedge raises baud_clk and tx_start together, so the accepting
    // edge also carries a tick.
    send_req(0, 9'h096);
    if_a.tx_start = 1'b0;
    check_frame(0, len, "tick_96", lat);
    checks++;
    if (!found || lat != 8) begin
      errors++;
      $display("FAIL tick_coincident_latency: cycles=%0d, required 8", lat);
    end
  endtask

  task automatic test_back_to_back();
    int len;
    int lat;
    len = push_frame(0, 9'h033);
    send_req(0, 9'h033);
    check_frame(0, len, "b2b_33", lat);
    // tx_start is still high here (tx_done cycle). The next edge accepts the new word.
    if_a.tx_data = 8'hC3;
    len = push_frame(0, 9'h0C3);
    @(posedge clk_in);
    #1;
    checks++;
    if (if_a.tx_busy !== 1'b1 || if_a.tx_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_reaccept: busy=%b done=%b, required 1 0", if_a.tx_busy, if_a.tx_done);
    end
    if_a.tx_start = 1'b0;
    check_frame(0, len, "b2b_C3", lat);
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset_midframe();
    bit seen;
    send_req(0, 9'h000);
    if_a.tx_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_in);
      #1;
      if (so_a === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    repeat (8 * 4 + 4) @(posedge clk_in);
    #1;
    checks++;
    if (!seen || so_a !== 1'b0 || if_a.tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_bit3: started=%0d line=%b busy=%b, required 1 0 1", seen, so_a, if_a.tx_busy);
    end
    @(negedge clk_in);
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    checks++;
    if (so_a !== 1'b1 || if_a.tx_busy !== 1'b0 || if_a.tx_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_next_edge: line=%b busy=%b done=%b, required 1 0 0", so_a, if_a.tx_busy, if_a.tx_done);
    end
    @(negedge clk_in);
    reset = 1'b0;
    run_word(0, 9'h0A5, "after_reset_A5");
  endtask

  initial begin
    reset         = 1'b1;
    if_a.tx_start = 1'b0;
    if_a.tx_data  = '0;
    if_b.tx_start = 1'b0;
    if_b.tx_data  = '0;
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_ignore_midframe();
    test_start_on_tick();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
